// File: rtl/sram_bloom_aging_pkg.sv
// Shared definitions for the Bloom filter counter aging sweep: FSM state encoding
// and the per-lane logical right shift also used by the Bloom filter update path.
package sram_bloom_aging_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RDW,
    WR
  } aging_state_e;

  // Widest SRAM word the shift helper supports; callers zero-extend into it.
  localparam int unsigned LANE_SHIFT_MAX_W = 128;
  localparam int unsigned LANE_SHIFT_IDX_W = $clog2(LANE_SHIFT_MAX_W);

  // Each lane of data_w/lane_w lanes is shifted right by shift with zero fill;
  // bits never cross a lane boundary.
  function automatic logic [LANE_SHIFT_MAX_W-1:0] lane_shift(
    input logic [LANE_SHIFT_MAX_W-1:0] data,
    input int unsigned                 data_w,
    input int unsigned                 lane_w,
    input int unsigned                 shift
  );
    logic [LANE_SHIFT_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < data_w; i++) begin
      if ((i % lane_w) + shift < lane_w) begin
        res[i[LANE_SHIFT_IDX_W-1:0]] = data[LANE_SHIFT_IDX_W'(i + shift)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_bloom_aging_timer.sv
// Sweep trigger: free-running period down-counter plus a single-bit pending latch
// that merges timer and software triggers.
module aging_timer #(
  parameter int unsigned PERIOD = 1 << 20
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic pending
);

  localparam int unsigned TW = $clog2(PERIOD);

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          fire;

  // A trigger arriving in the same cycle as clear is kept as the next queued sweep.
  always_comb begin
    fire      = (timer_q == '0);
    timer_d   = fire ? TW'(PERIOD - 1) : timer_q - TW'(1);
    pending_d = (pending_q & ~clear) | fire | start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= TW'(PERIOD - 1);
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/sram_bloom_aging.sv
// Periodic read-modify-write sweep that ages Bloom filter counters in SRAM.
// Optional SRAM_AGING_SKIP_ZERO_EN: all-zero words are not written back.
module sram_bloom_aging
  import sram_bloom_aging_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter int unsigned SRAM_DATA_WIDTH = 36,
  parameter int unsigned LANE_WIDTH      = 9,
  parameter int unsigned SHIFT           = 1,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned PERIOD          = 1 << 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic                       busy,
  output logic                       sweep_done
);

  localparam int unsigned AW = SRAM_ADDR_WIDTH;
  localparam int unsigned DW = SRAM_DATA_WIDTH;
  localparam int unsigned CW = $clog2(NUM_WORDS + 1);

  aging_state_e            state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           data_q, data_d;
  logic                    done_q, done_d;
  logic                    pending;
  logic                    clear_pending;
  logic                    last_word;
  logic                    word_done;
  logic [LANE_SHIFT_MAX_W-1:0] shifted;

  aging_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .clear  (clear_pending),
    .pending(pending)
  );

  if (DW < LANE_SHIFT_MAX_W) begin : g_shift_hi
    logic unused_shift_hi;
    assign unused_shift_hi = ^shifted[LANE_SHIFT_MAX_W-1:DW];
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    done_d        = 1'b0;
    clear_pending = 1'b0;
    word_done     = 1'b0;
    rd_req        = 1'b0;
    wr_req        = 1'b0;
    last_word     = (cnt_q == CW'(NUM_WORDS - 1));
    shifted       = lane_shift(LANE_SHIFT_MAX_W'(rd_data), DW, LANE_WIDTH, SHIFT);

    case (state_q)
      IDLE: begin
        if (pending && enable) begin
          clear_pending = 1'b1;
          addr_d        = AW'(BASE_ADDR);
          cnt_d         = '0;
          state_d       = RD;
        end
      end
      RD: begin
        // Request drops in the grant cycle so the arbiter never grants twice.
        rd_req = ~rd_ack;
        if (rd_ack) state_d = RDW;
      end
      RDW: begin
        if (rd_vld) begin
          data_d  = shifted[DW-1:0];
          state_d = WR;
`ifdef SRAM_AGING_SKIP_ZERO_EN
          if (rd_data == '0) word_done = 1'b1;
`endif
        end
      end
      WR: begin
        wr_req = ~wr_ack;
        if (wr_ack) word_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (last_word) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        addr_d  = addr_q + AW'(1);
        cnt_d   = cnt_q + CW'(1);
        state_d = RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr    = addr_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = (state_q != IDLE);
  assign sweep_done = done_q;

endmodule
